// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the memory-mapped IO register bank (LED, 7-seg data/base/enable,
//   switches, buttons) between two requesters: port 0 = CPU load/store unit,
//   port 1 = UART debug loader. Round-robin arbitration, one access per grant.
//   Sequence per transaction: IDLE (arbitrate + latch) -> ACCESS (gnt) -> RESP (ack).
// Ports
//   clk, rstn            clock, async active-low reset
//   req/we [1:0]         per-port request / write enable, held until gnt
//   addr/wdata [63:0]    {port1, port0} address / write data
//   gnt/ack [1:0]        one-hot pulses: access accepted / response valid
//   rdata [31:0], err    read data and unmapped-address flag, valid with ack
//   sw [15:0], btn [4:0] raw asynchronous inputs, synchronised internally
//   led_out, seg_data, seg_base, seg_en   register outputs to display blocks
module io_bus_arbiter #(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_FC00,
    parameter int          SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic        err,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [15:0] led_out,
    output logic [31:0] seg_data,
    output logic        seg_base,
    output logic [7:0]  seg_en
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        sel_q;
    logic        last_q;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        err_q;
    logic        win;

    logic [SYNC_STG-1:0][15:0] sw_sync;
    logic [SYNC_STG-1:0][4:0]  btn_sync;

    logic        dec_ok;
    logic        dec_wr_ok;
    logic [31:0] rd_val;

    // Tie goes to the port that was not served last; otherwise the sole requester.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    // Decode of the latched address; read mux and write legality.
    always_comb begin
        dec_ok    = 1'b0;
        dec_wr_ok = 1'b0;
        rd_val    = '0;
        if (acc_addr[31:8] == IO_BASE[31:8]) begin
            case (acc_addr[7:0])
                8'h60: begin dec_ok = 1'b1; dec_wr_ok = 1'b1; rd_val = {16'b0, led_out}; end
                8'h70: begin dec_ok = 1'b1; rd_val = {16'b0, sw_sync[SYNC_STG-1]}; end
                8'h74: begin dec_ok = 1'b1; rd_val = {27'b0, btn_sync[SYNC_STG-1]}; end
                8'h80: begin dec_ok = 1'b1; dec_wr_ok = 1'b1; rd_val = seg_data; end
                8'h84: begin dec_ok = 1'b1; dec_wr_ok = 1'b1; rd_val = {31'b0, seg_base}; end
                8'h88: begin dec_ok = 1'b1; dec_wr_ok = 1'b1; rd_val = {24'b0, seg_en}; end
                default: ;
            endcase
        end
    end

    // Next state and pulse outputs.
    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        ack     = 2'b00;
        err     = 1'b0;
        case (state_q)
            IDLE:   if (|req) state_d = ACCESS;
            ACCESS: begin
                gnt     = sel_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: begin
                ack     = sel_q ? 2'b10 : 2'b01;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_sync  <= '0;
            btn_sync <= '0;
        end else begin
            sw_sync  <= {sw_sync[SYNC_STG-2:0], sw};
            btn_sync <= {btn_sync[SYNC_STG-2:0], btn};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            led_out   <= '0;
            seg_data  <= '0;
            seg_base  <= 1'b0;
            seg_en    <= 8'hFF;
        end else begin
            if (state_q == IDLE && |req) begin
                sel_q     <= win;
                acc_we    <= we[win];
                acc_addr  <= win ? addr[63:32]  : addr[31:0];
                acc_wdata <= win ? wdata[63:32] : wdata[31:0];
            end
            if (state_q == ACCESS) begin
                last_q <= sel_q;
                err_q  <= ~dec_ok;
                rdata  <= acc_we ? 32'h0 : rd_val;
                // RO offsets decode but never write; unmapped writes are dropped.
                if (acc_we && dec_wr_ok) begin
                    case (acc_addr[7:0])
                        8'h60:   led_out  <= acc_wdata[15:0];
                        8'h80:   seg_data <= acc_wdata;
                        8'h84:   seg_base <= acc_wdata[0];
                        8'h88:   seg_en   <= acc_wdata[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

    logic        clk, rstn;
    logic [1:0]  req, we;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, ack;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [15:0] led_out;
    logic [31:0] seg_data;
    logic        seg_base;
    logic [7:0]  seg_en;

    int n_pass = 0;
    int n_tot  = 0;

    io_bus_arbiter dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .sw(sw), .btn(btn),
        .led_out(led_out), .seg_data(seg_data), .seg_base(seg_base), .seg_en(seg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Register map as a lookup: -1 = unmapped.
    function automatic int reg_of(input logic [31:0] a);
        if (a[31:8] != 24'hFFFFFC) return -1;
        case (a[7:0])
            8'h60: return 0;
            8'h70: return 1;
            8'h74: return 2;
            8'h80: return 3;
            8'h84: return 4;
            8'h88: return 5;
            default: return -1;
        endcase
    endfunction

    // Transaction-level model: a request seen while free is served over the
    // next two cycles (grant, then response). Compared every cycle.
    int          ph;
    int          m_sel, m_last;
    logic        m_we, m_err;
    logic [31:0] m_a, m_d, m_rd;
    logic [15:0] m_led;
    logic [31:0] m_seg;
    logic        m_base;
    logic [7:0]  m_en;

    initial begin
        ph = 0; m_sel = 0; m_last = 1; m_we = 0; m_err = 0; m_a = 0; m_d = 0; m_rd = 0;
        m_led = 0; m_seg = 0; m_base = 0; m_en = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ph = 0; m_last = 1; m_rd = 0; m_err = 0;
                m_led = 0; m_seg = 0; m_base = 0; m_en = 8'hFF;
                check("rst_rdata", rdata, 32'h0);
            end
            check("gnt", {30'b0, gnt}, (ph == 1) ? (m_sel ? 32'd2 : 32'd1) : 32'd0);
            check("ack", {30'b0, ack}, (ph == 2) ? (m_sel ? 32'd2 : 32'd1) : 32'd0);
            check("err", {31'b0, err}, {31'b0, (ph == 2) && m_err});
            if (ph == 2 && !m_we) check("rdata", rdata, m_rd);
            check("led_out", {16'b0, led_out}, {16'b0, m_led});
            check("seg_data", seg_data, m_seg);
            check("seg_base", {31'b0, seg_base}, {31'b0, m_base});
            check("seg_en", {24'b0, seg_en}, {24'b0, m_en});
            if (rstn) begin
                case (ph)
                    0: if (req != 2'b00) begin
                        m_sel = (req == 2'b11) ? (m_last == 1 ? 0 : 1) : (req[1] ? 1 : 0);
                        m_a   = m_sel ? addr[63:32]  : addr[31:0];
                        m_d   = m_sel ? wdata[63:32] : wdata[31:0];
                        m_we  = we[m_sel];
                        ph    = 1;
                    end
                    1: begin
                        int r;
                        r     = reg_of(m_a);
                        m_err = (r < 0);
                        case (r)
                            0: m_rd = {16'b0, m_led};
                            1: m_rd = {16'b0, sw};
                            2: m_rd = {27'b0, btn};
                            3: m_rd = m_seg;
                            4: m_rd = {31'b0, m_base};
                            5: m_rd = {24'b0, m_en};
                            default: m_rd = 32'h0;
                        endcase
                        if (m_we) begin
                            if (r == 0) m_led  = m_d[15:0];
                            if (r == 3) m_seg  = m_d;
                            if (r == 4) m_base = m_d[0];
                            if (r == 5) m_en   = m_d[7:0];
                        end
                        m_last = m_sel;
                        ph     = 2;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin addr[31:0]  = a; wdata[31:0]  = d; we[0] = w; req[0] = 1'b1; end
        else        begin addr[63:32] = a; wdata[63:32] = d; we[1] = w; req[1] = 1'b1; end
    endtask

    // Single-port transaction; lat = negedges from request drive to grant.
    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        bit got;
        got = 0; lat = 0;
        @(posedge clk); #1;
        drive(p, w, a, d);
        while (!got && lat < 10) begin
            @(negedge clk); lat++;
            if (gnt[p]) got = 1;
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
        @(negedge clk);
        rd = rdata; e = err;
        check("ack_after_gnt", {30'b0, ack}, (p == 1) ? 32'd2 : 32'd1);
    endtask

    logic [1:0] gseq[$];
    int         gcyc[$];

    // Both ports request continuously until n grants were observed.
    task automatic both_run(input int n);
        int cnt, cyc;
        cnt = 0; cyc = 0;
        gseq.delete(); gcyc.delete();
        @(posedge clk); #1;
        req = 2'b11;
        while (cnt < n && cyc < 100) begin
            @(negedge clk); cyc++;
            if (gnt != 2'b00) begin gseq.push_back(gnt); gcyc.push_back(cyc); cnt++; end
        end
        if (cnt < n) check("both_timeout", cnt, n);
        @(posedge clk); #1;
        req = 2'b00;
        repeat (3) @(posedge clk);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; sw = 0; btn = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_seg_en", {24'b0, seg_en}, 32'h0000_00FF);

        // 1: port0 LED write
        txn(0, 1'b1, 32'hFFFF_FC60, 32'h0000_A5A5, rd, e, lat);
        check("t1_latency", lat, 2);
        check("t1_led", {16'b0, led_out}, 32'h0000_A5A5);
        check("t1_err", {31'b0, e}, 32'h0);

        // 3: synchronised switch read on port1
        sw = 16'h00F0; btn = 5'h15;
        repeat (4) @(posedge clk);
        txn(1, 1'b0, 32'hFFFF_FC70, 32'h0, rd, e, lat);
        check("t3_rdata", rd, 32'h0000_00F0);
        check("t3_err", {31'b0, e}, 32'h0);
        txn(1, 1'b0, 32'hFFFF_FC74, 32'h0, rd, e, lat);
        check("btn_rdata", rd, 32'h0000_0015);

        // 2: simultaneous SEG_DATA writes
        addr  = {32'hFFFF_FC80, 32'hFFFF_FC80};
        wdata = {32'h2222_2222, 32'h1111_1111};
        we    = 2'b11;
        both_run(2);
        check("t2_first", {30'b0, gseq[0]}, 32'd1);
        check("t2_second", {30'b0, gseq[1]}, 32'd2);
        check("t2_spacing", gcyc[1] - gcyc[0], 3);
        check("t2_seg", seg_data, 32'h2222_2222);

        // 5: sustained contention, six grants alternate
        addr  = {32'hFFFF_FC60, 32'hFFFF_FC80};
        we    = 2'b00;
        both_run(6);
        for (int i = 0; i < 6; i++) begin
            check("t5_order", {30'b0, gseq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("t5_spacing", gcyc[i] - gcyc[i-1], 3);
        end

        // 4: unmapped offset, window miss, RO write, readbacks
        txn(0, 1'b0, 32'hFFFF_FC90, 32'h0, rd, e, lat);
        check("t4_rd_rdata", rd, 32'h0);
        check("t4_rd_err", {31'b0, e}, 32'h1);
        txn(0, 1'b1, 32'hFFFF_FC90, 32'h0000_1000, rd, e, lat);
        check("t4_wr_err", {31'b0, e}, 32'h1);
        txn(0, 1'b1, 32'hFFFF_FD60, 32'h0000_FFFF, rd, e, lat);
        check("miss_err", {31'b0, e}, 32'h1);
        check("miss_led", {16'b0, led_out}, 32'h0000_A5A5);
        txn(1, 1'b1, 32'hFFFF_FC70, 32'h0000_1234, rd, e, lat);
        check("ro_wr_err", {31'b0, e}, 32'h0);
        txn(0, 1'b1, 32'hFFFF_FC84, 32'h0000_0003, rd, e, lat);
        check("seg_base_bit0", {31'b0, seg_base}, 32'h1);
        txn(1, 1'b0, 32'hFFFF_FC60, 32'h0, rd, e, lat);
        check("led_readback", rd, 32'h0000_A5A5);

        // 6: reset during ACCESS of a SEG_EN write
        @(posedge clk); #1;
        drive(0, 1'b1, 32'hFFFF_FC88, 32'h0000_000F);
        lat = 0;
        while (gnt[0] !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        check("t6_gnt_seen", {31'b0, gnt[0]}, 32'h1);
        #1 rstn = 1'b0; req = 2'b00;
        repeat (2) @(negedge clk);
        check("t6_seg_en", {24'b0, seg_en}, 32'h0000_00FF);
        check("t6_no_ack", {30'b0, ack}, 32'h0);
        @(posedge clk); #1 rstn = 1'b1;
        txn(0, 1'b1, 32'hFFFF_FC88, 32'h0000_003C, rd, e, lat);
        check("t6_after_lat", lat, 2);
        check("t6_after_en", {24'b0, seg_en}, 32'h0000_003C);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
